// File: rtl/truth_table_capture_if.sv
// truth_table_capture_if: bundles the sweep-control, block-under-test and result signals of truth_table_capture.
// TTC_MISMATCH_COUNT_EN adds the mismatch_cnt result.
interface truth_table_capture_if;
  logic        start;
  logic [15:0] expected;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        y;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;
  logic        err_valid;
  logic [3:0]  first_err;
`ifdef TTC_MISMATCH_COUNT_EN
  logic [4:0]  mismatch_cnt;
  modport master (
    output start, expected, y,
    input  a, b, c, d, busy, done, table_out, pass, err_valid, first_err, mismatch_cnt
  );
  modport slave (
    input  start, expected, y,
    output a, b, c, d, busy, done, table_out, pass, err_valid, first_err, mismatch_cnt
  );
`else
  modport master (
    output start, expected, y,
    input  a, b, c, d, busy, done, table_out, pass, err_valid, first_err
  );
  modport slave (
    input  start, expected, y,
    output a, b, c, d, busy, done, table_out, pass, err_valid, first_err
  );
`endif
endinterface

// File: rtl/truth_table_capture.sv
// truth_table_capture: drives all 16 vectors of a 4-input block, captures y into a truth table, compares to a golden table.
// Define TTC_MISMATCH_COUNT_EN to add the mismatch_cnt output.
module truth_table_capture #(
  parameter int SETTLE = 2
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_capture_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] L_LAST   = 4'(SETTLE - 1);
  logic [1:0]  r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_first;
  logic [15:0] r_exp;
  logic [15:0] r_table;
  logic        r_pass;
  logic        r_err;
  logic        r_done;
  logic        w_active;
  logic        w_accept;
  logic        w_mis;
  assign w_active = r_state == S_DRIVE || r_state == S_SAMPLE;
  assign w_accept = r_state == S_IDLE && bus.start;
  assign w_mis    = bus.y != r_exp[r_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_first <= '0;
      r_exp   <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_exp   <= bus.expected;
          r_table <= '0;
          r_err   <= 1'b0;
          r_first <= '0;
          r_pass  <= 1'b0;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_state <= S_DRIVE;
        end
        S_DRIVE: begin
          r_cnt   <= r_cnt + 4'd1;
          r_state <= r_cnt == L_LAST ? S_SAMPLE : S_DRIVE;
        end
        S_SAMPLE: begin
          r_table[r_idx] <= bus.y;
          if (w_mis && !r_err) begin
            r_err   <= 1'b1;
            r_first <= r_idx;
          end
          // leave on state at vector 15 so the index never wraps
          if (r_idx == 4'd15) r_state <= S_DONE;
          else begin
            r_idx   <= r_idx + 4'd1;
            r_cnt   <= '0;
            r_state <= S_DRIVE;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_pass  <= ~r_err;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
`ifdef TTC_MISMATCH_COUNT_EN
  logic [4:0] r_mcnt;
  always_ff @(posedge clk) begin
    if (rst) r_mcnt <= '0;
    else if (w_accept) r_mcnt <= '0;
    else if (r_state == S_SAMPLE && w_mis) r_mcnt <= r_mcnt + 5'd1;
  end
  assign bus.mismatch_cnt = r_mcnt;
`endif
  assign {bus.a, bus.b, bus.c, bus.d} = w_active ? r_idx : 4'd0;
  assign bus.busy      = w_active;
  assign bus.done      = r_done;
  assign bus.table_out = r_table;
  assign bus.pass      = r_pass;
  assign bus.err_valid = r_err;
  assign bus.first_err = r_first;
endmodule

// File: tb/tb_truth_table_capture.sv
// tb_truth_table_capture: vector table plus random sweeps on SETTLE=2 and SETTLE=1 instances, with a slow-settling block model.
module tb_truth_table_capture;
  typedef struct {
    logic        sel;
    logic        glitch;
    logic [15:0] fn;
    logic [15:0] exp;
    logic [15:0] tbl;
    logic        pass;
    logic        err;
    logic [3:0]  first;
    logic [4:0]  cnt;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        st = 1'b0;
  logic [15:0] ex = '0;
  logic [15:0] fn = '0;
  logic [3:0]  d0a, d0b, d1;
  int          checks = 0;
  int          errors = 0;
  vec_t        tv[13];
  always #5 clk = ~clk;
  truth_table_capture_if b0();
  truth_table_capture_if b1();
  truth_table_capture #(.SETTLE(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  truth_table_capture #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  assign b0.start    = st & ~sel;
  assign b1.start    = st & sel;
  assign b0.expected = ex;
  assign b1.expected = ex;
  // block under test whose output lags the vector by exactly SETTLE cycles
  always_ff @(posedge clk) begin
    d0a <= {b0.a, b0.b, b0.c, b0.d};
    d0b <= d0a;
    d1  <= {b1.a, b1.b, b1.c, b1.d};
  end
  assign b0.y = fn[d0b];
  assign b1.y = fn[d1];
  logic [15:0] o_tbl;
  logic [3:0]  o_vec, o_first;
  logic        o_busy, o_done, o_pass, o_err;
  assign o_tbl   = sel ? b1.table_out : b0.table_out;
  assign o_vec   = sel ? {b1.a, b1.b, b1.c, b1.d} : {b0.a, b0.b, b0.c, b0.d};
  assign o_first = sel ? b1.first_err : b0.first_err;
  assign o_busy  = sel ? b1.busy : b0.busy;
  assign o_done  = sel ? b1.done : b0.done;
  assign o_pass  = sel ? b1.pass : b0.pass;
  assign o_err   = sel ? b1.err_valid : b0.err_valid;
`ifdef TTC_MISMATCH_COUNT_EN
  logic [4:0] o_cnt;
  assign o_cnt = sel ? b1.mismatch_cnt : b0.mismatch_cnt;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  function automatic vec_t model(input logic s, input logic g, input logic [15:0] f, input logic [15:0] e);
    vec_t v;
    logic [15:0] m;
    m = f ^ e;
    v.sel = s; v.glitch = g; v.fn = f; v.exp = e; v.tbl = f;
    v.pass = m == 16'd0;
    v.err = m != 16'd0;
    v.first = '0;
    v.cnt = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) v.first = 4'(i);
    for (int i = 0; i < 16; i++) v.cnt += 5'(m[i]);
    return v;
  endfunction
  task automatic run(input vec_t v);
    int cyc;
    int lat;
    lat = v.sel ? 33 : 49;
    @(negedge clk);
    sel = v.sel; fn = v.fn; ex = v.exp; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    cyc = 0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("pass_cleared", 32'(o_pass), 32'd0);
    while (!o_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (v.glitch) begin
        st = cyc == 5 || cyc == 20;
        if (cyc == 10) ex = ~v.exp;
      end
    end
    st = 1'b0;
    chk("done_latency", 32'(cyc), 32'(lat));
    chk("table_out", 32'(o_tbl), 32'(v.tbl));
    chk("pass", 32'(o_pass), 32'(v.pass));
    chk("err_valid", 32'(o_err), 32'(v.err));
    chk("first_err", 32'(o_first), 32'(v.first));
`ifdef TTC_MISMATCH_COUNT_EN
    chk("mismatch_cnt", 32'(o_cnt), 32'(v.cnt));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_not_busy", 32'(o_busy), 32'd0);
    chk("idle_vector", 32'(o_vec), 32'd0);
    chk("hold_table", 32'(o_tbl), 32'(v.tbl));
    chk("hold_pass", 32'(o_pass), 32'(v.pass));
  endtask
  initial begin
    tv[0] = '{1'b0, 1'b0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 1'b1, 1'b0, 4'd0, 5'd0};
    tv[1] = '{1'b0, 1'b0, 16'hFFF0, 16'hFFF1, 16'hFFF0, 1'b0, 1'b1, 4'd0, 5'd1};
    tv[2] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'd0, 5'd16};
    tv[3] = '{1'b0, 1'b1, 16'hFFF0, 16'hFFF0, 16'hFFF0, 1'b1, 1'b0, 4'd0, 5'd0};
    tv[4] = '{1'b1, 1'b0, 16'h6996, 16'h6996, 16'h6996, 1'b1, 1'b0, 4'd0, 5'd0};
    tv[5] = '{1'b1, 1'b0, 16'h6996, 16'h6986, 16'h6996, 1'b0, 1'b1, 4'd4, 5'd1};
    tv[6] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1, 4'd15, 5'd1};
    for (int k = 7; k < 13; k++) begin
      logic [15:0] f, m;
      f = 16'($urandom);
      m = 16'($urandom & $urandom & $urandom);
      tv[k] = model(k[0], 1'b0, f, f ^ m);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_table", 32'(o_tbl), 32'd0);
    chk("rst_pass", 32'(o_pass), 32'd0);
    for (int k = 0; k < 13; k++) run(tv[k]);
    @(negedge clk);
    sel = 1'b0; fn = 16'hFFF0; ex = 16'h0000; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (29) @(negedge clk);
    chk("midsweep_err_set", 32'(o_err), 32'd1);
    rst = 1'b1;
    st = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st = 1'b0;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_vector", 32'(o_vec), 32'd0);
    chk("midrst_table", 32'(o_tbl), 32'd0);
    chk("midrst_err", 32'(o_err), 32'd0);
    chk("midrst_first", 32'(o_first), 32'd0);
    chk("midrst_pass", 32'(o_pass), 32'd0);
`ifdef TTC_MISMATCH_COUNT_EN
    chk("midrst_cnt", 32'(o_cnt), 32'd0);
`endif
    run(model(1'b0, 1'b0, 16'hFFF0, 16'hFFF0));
    run(model(1'b1, 1'b0, 16'($urandom), 16'($urandom)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
